// File: rtl/rt_pkg.sv
// Shared RISC_TOY constants and opcode decode used by ID to derive operand use and result issue.
package rt_pkg;

    localparam int RT_DW    = 32;
    localparam int RT_AW    = 5;
    localparam int RT_ENTRY = 32;

    typedef enum logic [4:0] {
        OP_ADDI = 5'd0,
        OP_ANDI = 5'd1,
        OP_ORI  = 5'd2,
        OP_MOVI = 5'd3,
        OP_ADD  = 5'd4,
        OP_SUB  = 5'd5,
        OP_NEG  = 5'd6,
        OP_NOT  = 5'd7,
        OP_AND  = 5'd8,
        OP_OR   = 5'd9,
        OP_XOR  = 5'd10,
        OP_LSR  = 5'd11,
        OP_ASR  = 5'd12,
        OP_SHL  = 5'd13,
        OP_ROR  = 5'd14,
        OP_BR   = 5'd15,
        OP_BRL  = 5'd16,
        OP_J    = 5'd17,
        OP_JL   = 5'd18,
        OP_LD   = 5'd19,
        OP_ST   = 5'd20,
        OP_LDR  = 5'd21,
        OP_STR  = 5'd22
    } rt_op_e;

    typedef struct packed {
        logic wr_ra;
        logic use_ra;
        logic use_rb;
        logic use_rc;
    } rt_op_use_t;

    // ST/STR read ra as store data; every other ra reference is a destination.
    function automatic rt_op_use_t rt_op_use(input rt_op_e op);
        rt_op_use_t u;
        u = '0;
        case (op)
            OP_ADDI, OP_ANDI, OP_ORI, OP_LD: begin
                u.wr_ra  = 1'b1;
                u.use_rb = 1'b1;
            end
            OP_MOVI, OP_JL, OP_LDR: u.wr_ra = 1'b1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_LSR, OP_ASR, OP_SHL, OP_ROR, OP_BRL: begin
                u.wr_ra  = (op != OP_BR);
                u.use_rb = 1'b1;
                u.use_rc = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                u.wr_ra  = 1'b1;
                u.use_rc = 1'b1;
            end
            OP_BR: begin
                u.use_rb = 1'b1;
                u.use_rc = 1'b1;
            end
            OP_ST: begin
                u.use_ra = 1'b1;
                u.use_rb = 1'b1;
            end
            OP_STR: u.use_ra = 1'b1;
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/rt_sb_cnt.sv
// One pending-write scoreboard counter: saturating up on issue, down on retire, flags retire-at-zero.
module rt_sb_cnt
    import rt_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          err
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    assign err = dec & (cnt == '0);

    // Simultaneous issue and retire cancel out; the counter never wraps either way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/rt_regfile_sb.sv
// Multi-read-port register file with per-register pending-write scoreboard and ID stall request.
// Build option: define RT_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module rt_regfile_sb
    import rt_pkg::*;
#(
    parameter int DW    = RT_DW,
    parameter int AW    = RT_AW,
    parameter int ENTRY = RT_ENTRY,
    parameter int NRP   = 2,
    parameter int CW    = 2
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [NRP*AW-1:0] RA,
    input  logic [NRP-1:0]    RUSE,
    output logic [NRP*DW-1:0] RD,
    output logic [NRP-1:0]    RBUSY,
    output logic              STALL,
    input  logic              ISSUE,
    input  logic [AW-1:0]     ISSUE_DST,
    output logic              ISSUE_RDY,
    input  logic              WEN,
    input  logic [AW-1:0]     WA,
    input  logic [DW-1:0]     WDATA,
    output logic              SB_ERR
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [DW-1:0]    mem [ENTRY];
    logic [CW-1:0]    cnt [ENTRY];
    logic [ENTRY-1:0] inc_vec;
    logic [ENTRY-1:0] dec_vec;
    logic [ENTRY-1:0] err_vec;
    logic [CW-1:0]    issue_cnt;

    // Addresses with no matching entry select nothing, so out-of-range accesses fall out as no-ops.
    always_comb begin
        issue_cnt = '0;
        for (int r = 0; r < ENTRY; r++) begin
            if (ISSUE_DST == AW'(r)) issue_cnt = cnt[r];
        end
    end

    assign ISSUE_RDY = (issue_cnt != CNT_MAX);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < ENTRY; r++) begin
            inc_vec[r] = ISSUE & ISSUE_RDY & (ISSUE_DST == AW'(r));
            dec_vec[r] = WEN & (WA == AW'(r));
        end
    end

    for (genvar g = 0; g < ENTRY; g++) begin : g_cnt
        rt_sb_cnt #(.CW(CW)) u_cnt (
            .clk   (CLK),
            .rst_n (RSTN),
            .inc   (inc_vec[g]),
            .dec   (dec_vec[g]),
            .cnt   (cnt[g]),
            .err   (err_vec[g])
        );
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int r = 0; r < ENTRY; r++) mem[r] <= '0;
        end else begin
            for (int r = 0; r < ENTRY; r++) begin
                if (WEN && (WA == AW'(r))) mem[r] <= WDATA;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            SB_ERR <= 1'b0;
        end else if (|err_vec) begin
            SB_ERR <= 1'b1;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_v;
        logic [CW-1:0] rcnt;
        logic          busy;
`ifdef RT_RF_BYPASS_EN
        logic          hit;
`endif

        assign ra = RA[p*AW +: AW];

        always_comb begin
            rd_v = '0;
            rcnt = '0;
`ifdef RT_RF_BYPASS_EN
            hit  = 1'b0;
`endif
            for (int r = 0; r < ENTRY; r++) begin
                if (ra == AW'(r)) begin
                    rd_v = mem[r];
                    rcnt = cnt[r];
`ifdef RT_RF_BYPASS_EN
                    hit  = 1'b1;
`endif
                end
            end
            busy = (rcnt != '0);
`ifdef RT_RF_BYPASS_EN
            // The retiring write carries the last outstanding value, so the consumer can take it now.
            if (hit && WEN && (WA == ra)) begin
                rd_v = WDATA;
                if (rcnt == CW'(1)) busy = 1'b0;
            end
`endif
        end

        assign RD[p*DW +: DW] = rd_v;
        assign RBUSY[p]       = busy;
    end

    assign STALL = |(RUSE & RBUSY);

endmodule
